// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states, result tag type and sizing helpers for conv_window_scheduler
package conv_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    localparam int COORD_W = 16;
    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } tag_t;
    function automatic int out_rows(input int h, input int kh);
        return h - kh + 1;
    endfunction
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/conv_tag_pipe.sv
// conv_tag_pipe: enable-gated tag shift register; the registered tail lines up with datapath data_out
module conv_tag_pipe
    import conv_pkg::*;
#(
    parameter int PIPE_LATENCY = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  tag_t in_tag,
    output tag_t res_tag
);
    tag_t tail_in;
    generate
        if (PIPE_LATENCY == 1) begin : g_direct
            assign tail_in = in_tag;
        end else begin : g_shift
            tag_t sr [PIPE_LATENCY-1];
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_LATENCY-1; i++) sr[i] <= '0;
                end else if (en) begin
                    sr[0] <= in_tag;
                    for (int i = 1; i < PIPE_LATENCY-1; i++) sr[i] <= sr[i-1];
                end
            assign tail_in = sr[PIPE_LATENCY-2];
        end
    endgenerate
    // coordinates only follow valid tags so they hold across invalid shifts and stalls
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            res_tag <= '0;
        end else begin
            res_tag.valid <= en & tail_in.valid;
            if (en && tail_in.valid) begin
                res_tag.x <= tail_in.x;
                res_tag.y <= tail_in.y;
            end
        end
endmodule

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: feeds one frame of column beats into the windowed convolution datapath and tags results.
// Optional CONV_SCHED_PERF_CNT_EN adds the stall_cycles counter output.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int DATA_WIDTH    = 16,
    parameter int IMG_WIDTH     = 32,
    parameter int IMG_HEIGHT    = 32,
    parameter int PIPE_LATENCY  = 5
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic                                pix_valid,
    output logic                                pix_ready,
    input  logic [KERNEL_HEIGHT*DATA_WIDTH-1:0] col_in,
    output logic                                win_en,
    output logic [KERNEL_HEIGHT*DATA_WIDTH-1:0] win_col,
    output logic                                res_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]        res_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]       res_y,
    output logic                                busy,
    output logic                                frame_done
`ifdef CONV_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                         stall_cycles
`endif
);
    localparam int OUT_ROWS = out_rows(IMG_HEIGHT, KERNEL_HEIGHT);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int FW = cnt_w(PIPE_LATENCY);
    state_t        state;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [FW-1:0] fcnt;
    logic          accept, last_col, last_row, unused_tag;
    tag_t          in_tag, res_tag;
    assign accept     = state == RUN && pix_valid;
    assign last_col   = col == XW'(IMG_WIDTH-1);
    assign last_row   = row == YW'(OUT_ROWS-1);
    assign pix_ready  = state == RUN;
    assign win_en     = accept || state == FLUSH;
    assign win_col    = accept ? col_in : '0;
    assign busy       = state != IDLE;
    assign frame_done = state == DONE;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            fcnt  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    col   <= '0;
                    row   <= '0;
                end
                RUN: if (pix_valid) begin
                    col <= last_col ? '0 : col + 1'b1;
                    if (last_col && last_row) begin
                        state <= FLUSH;
                        row   <= '0;
                        fcnt  <= '0;
                    end else if (last_col) begin
                        row <= row + 1'b1;
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + 1'b1;
                    if (fcnt == FW'(PIPE_LATENCY-1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    // the first KERNEL_WIDTH-1 beats of a row still hold the previous row's columns
    assign in_tag = '{valid: accept && col >= XW'(KERNEL_WIDTH-1),
                      x:     COORD_W'(col - XW'(KERNEL_WIDTH-1)),
                      y:     COORD_W'(row)};
    conv_tag_pipe #(.PIPE_LATENCY(PIPE_LATENCY)) u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (win_en),
        .in_tag  (in_tag),
        .res_tag (res_tag)
    );
    assign res_valid  = res_tag.valid;
    assign res_x      = res_tag.x[XW-1:0];
    assign res_y      = res_tag.y[YW-1:0];
    assign unused_tag = ^{res_tag.x, res_tag.y};
`ifdef CONV_SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            stall_cycles <= '0;
        else if (state == IDLE && start)
            stall_cycles <= '0;
        else if (state == RUN && !pix_valid && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler: randomized frames checked against a timing model built from enabled-cycle lists
module tb_conv_window_scheduler;
    localparam int KW = 3, KH = 3, DW = 16, IW = 8, IH = 5, PL = 5;
    localparam int OR = IH - KH + 1, NB = IW * OR, NRES = (IW - KW + 1) * OR;
    localparam int XW = $clog2(IW), YW = $clog2(IH);
    logic clk = 0, reset_n = 0, start = 0, pix_valid = 0;
    logic [KH*DW-1:0] col_in = '0, win_col;
    logic pix_ready, win_en, res_valid, busy, frame_done;
    logic [XW-1:0] res_x;
    logic [YW-1:0] res_y;
`ifdef CONV_SCHED_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    conv_window_scheduler #(
        .KERNEL_WIDTH(KW), .KERNEL_HEIGHT(KH), .DATA_WIDTH(DW),
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .PIPE_LATENCY(PL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .col_in(col_in), .win_en(win_en), .win_col(win_col),
        .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .busy(busy),
        .frame_done(frame_done)
`ifdef CONV_SCHED_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({pix_ready, win_en, win_col, res_valid, res_x, res_y, busy, frame_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {pix_ready, win_en, res_valid, res_x, res_y, busy, frame_done});
        end
`ifdef CONV_SCHED_PERF_CNT_EN
        total++;
        if (stall_cycles !== 32'd0) begin
            bad++;
            $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
        end
`endif
        @(posedge clk) #1 reset_n = 1;
    endtask

    // mode 0: pix_valid held; mode 1: slen idle cycles after beat 4; mode 2: random valid
    task automatic test_frame(input string name, input int mode, input int slen, input bit poke);
        int e[$], pc[$], px[$], py[$];
        int beats = 0, fl = 0, phase = 1, stalls = 0, tail = 0, c, nexp, k;
        bit pv, xen, xrdy, xbusy, xdone;
        logic [KH*DW-1:0] ci, xcol;
        @(posedge clk) #1 start = 1;
        @(posedge clk) #1 start = 0;
        for (c = 0; c < 500 && tail < PL + 3; c++) begin
            if (phase != 1) pv = $urandom_range(0, 1) == 1;
            else if (mode == 1) pv = !(beats == 4 && stalls < slen);
            else if (mode == 2) pv = $urandom_range(0, 3) != 0;
            else pv = 1;
            ci = (KH*DW)'({$urandom(), $urandom()});
            pix_valid = pv;
            col_in = ci;
            start = poke && (phase == 1 || phase == 2) ? $urandom_range(0, 1) == 1 : 1'b0;
            xen = phase == 1 ? pv : phase == 2;
            xrdy = phase == 1;
            xbusy = phase != 0;
            xdone = phase == 3;
            xcol = (phase == 1 && pv) ? ci : '0;
            @(negedge clk);
            total++;
            if ({win_en, pix_ready, busy, frame_done} !== {xen, xrdy, xbusy, xdone}) begin
                bad++;
                $display("FAIL %s ctl cyc=%0d got=%b exp=%b", name, c,
                         {win_en, pix_ready, busy, frame_done}, {xen, xrdy, xbusy, xdone});
            end
            total++;
            if (win_col !== xcol) begin
                bad++;
                $display("FAIL %s win_col cyc=%0d got=%h exp=%h", name, c, win_col, xcol);
            end
            if (res_valid === 1'b1) begin
                pc.push_back(c);
                px.push_back(int'(res_x));
                py.push_back(int'(res_y));
            end
`ifdef CONV_SCHED_PERF_CNT_EN
            if (c == 0 || phase == 3) begin
                total++;
                if (stall_cycles !== 32'(stalls)) begin
                    bad++;
                    $display("FAIL %s stall_cycles cyc=%0d got=%0d exp=%0d", name, c, stall_cycles, stalls);
                end
            end
`endif
            if (xen) e.push_back(c);
            if (phase == 1) begin
                if (pv) beats++;
                else stalls++;
            end
            if (phase == 1 && beats == NB) phase = 2;
            else if (phase == 2) begin
                fl++;
                if (fl == PL) phase = 3;
            end else if (phase == 3) phase = 0;
            else if (phase == 0) tail++;
            @(posedge clk) #1;
        end
        start = 0;
        pix_valid = 0;
        total++;
        if (phase != 0) begin
            bad++;
            $display("FAIL %s frame_timeout got=phase%0d exp=finished", name, phase);
        end
        // beat b's result emerges the cycle after its PL-th enabled cycle
        nexp = 0;
        k = 0;
        for (int b = 0; b < NB; b++) begin
            if (b % IW < KW - 1) continue;
            nexp++;
            if (b + PL - 1 >= e.size() || k >= pc.size()) continue;
            total++;
            if (pc[k] != e[b+PL-1] + 1 || px[k] != b % IW - (KW - 1) || py[k] != b / IW) begin
                bad++;
                $display("FAIL %s result%0d got=cyc%0d(%0d,%0d) exp=cyc%0d(%0d,%0d)", name, k,
                         pc[k], px[k], py[k], e[b+PL-1] + 1, b % IW - (KW - 1), b / IW);
            end
            k++;
        end
        total++;
        if (pc.size() != nexp || nexp != NRES) begin
            bad++;
            $display("FAIL %s result_count got=%0d exp=%0d", name, pc.size(), NRES);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk) #1 start = 1;
        @(posedge clk) #1 start = 0;
        pix_valid = 1;
        repeat (IW + 1) @(posedge clk);
        #1 reset_n = 0;
        #2;
        total++;
        if ({pix_ready, win_en, win_col, res_valid, res_x, res_y, busy, frame_done} !== '0) begin
            bad++;
            $display("FAIL reset_mid_async got=%b exp=0", {pix_ready, win_en, res_valid, res_x, res_y, busy, frame_done});
        end
        @(posedge clk) #1 reset_n = 1;
        repeat (PL + 2) begin
            @(negedge clk);
            total++;
            if ({pix_ready, win_en, res_valid, busy, frame_done} !== 5'b0) begin
                bad++;
                $display("FAIL reset_mid_idle got=%b exp=00000", {pix_ready, win_en, res_valid, busy, frame_done});
            end
        end
        pix_valid = 0;
    endtask

    initial begin
        test_reset();
        test_frame("basic", 0, 0, 0);
        test_frame("stall3", 1, 3, 0);
        test_frame("start_poke", 0, 0, 1);
        test_reset_mid();
        test_frame("after_reset", 0, 0, 0);
        test_frame("stall7", 1, 7, 0);
        test_frame("cleared", 0, 0, 0);
        repeat (3) test_frame("random", 2, 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
- Sequences one frame of column beats into the enable-gated sliding-window convolution datapath, which sits downstream of the line buffer.
- Accepts KERNEL_HEIGHT-pixel columns over a valid/ready handshake and drives the datapath column and enable.
- Tracks column and row position, and tags each datapath result as valid or invalid (row-border suppression) with output coordinates.
- Drains the datapath pipeline at end of frame and signals frame completion.

Parameters:
- KERNEL_WIDTH, 3, window columns
- KERNEL_HEIGHT, 3, window rows / pixels per column beat
- DATA_WIDTH, 16, pixel width
- IMG_WIDTH, 32, column beats per row (must be >= KERNEL_WIDTH)
- IMG_HEIGHT, 32, input image rows (must be >= KERNEL_HEIGHT); output rows OUT_ROWS = IMG_HEIGHT-KERNEL_HEIGHT+1
- PIPE_LATENCY, 5, enabled cycles from column load to datapath data_out update (must be >= 1)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled in IDLE only
- pix_valid  in  1  col_in valid
- pix_ready  out  1  beat accepted when pix_valid & pix_ready
- col_in  in  KERNEL_HEIGHT*DATA_WIDTH  column beat, row i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- win_en  out  1  datapath clock enable
- win_col  out  KERNEL_HEIGHT*DATA_WIDTH  column to datapath
- res_valid  out  1  datapath data_out holds a valid result this cycle
- res_x  out  $clog2(IMG_WIDTH)  output column of result
- res_y  out  $clog2(IMG_HEIGHT)  output row of result
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; counters and tag pipeline cleared.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start=1 -> RUN; col=0, row=0.
  - Otherwise hold.
- RUN:
  - pix_ready=1 (combinational from state).
  - Beat accepted -> win_en=1, win_col=col_in.
  - No beat -> win_en=0, win_col=0; the datapath and tags freeze, so no bubble enters the window.
  - Accepted beat advances col; wrap at IMG_WIDTH-1 to 0 and increment row.
  - Beat at col=IMG_WIDTH-1, row=OUT_ROWS-1 -> FLUSH; flush counter=0.
- FLUSH:
  - pix_ready=0, win_en=1, win_col=0, for exactly PIPE_LATENCY cycles; then DONE.
- DONE:
  - frame_done=1 for one cycle; -> IDLE.
- Tag pipeline:
  - PIPE_LATENCY-deep shift register of {valid, x, y}; advances only when win_en=1.
  - Entry for an accepted beat: valid = (col >= KERNEL_WIDTH-1), x = col-(KERNEL_WIDTH-1), y = row.
  - FLUSH inserts invalid entries.
- res_valid/res_x/res_y:
  - Registered from the tail entry.
  - res_valid is 1 only in the cycle after an enabled shift moved a valid tag into the tail; this is coincident with the datapath data_out update.
  - Otherwise res_valid=0; res_x/res_y hold their values.
- Results per frame: exactly (IMG_WIDTH-KERNEL_WIDTH+1)*OUT_ROWS, in raster order.
- Border suppression: the first KERNEL_WIDTH-1 beats of each row mix in columns from the previous row; they are tagged invalid.
- start while busy: ignored.
- pix_valid outside RUN: ignored; nothing is accepted.
- Reset mid-frame: immediate abort to IDLE with no frame_done; tags cleared, so no stale res_valid.
- Counter widths: $clog2 of the range; no overflow at the terminal beat.

Optional Feature:
- Macro: CONV_SCHED_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0], counting RUN cycles with pix_valid=0.
  - Cleared on start accepted in IDLE; saturates at 32'hFFFFFFFF; holds after the frame.
  - Reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package conv_pkg:
  - State enum typedef (IDLE, RUN, FLUSH, DONE).
  - Tag struct typedef {valid, x, y}.
  - Localparam helpers for OUT_ROWS and coordinate widths.
- One sub-module: conv_tag_pipe, the enable-gated PIPE_LATENCY-deep tag shift register with registered tail outputs.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=5, K=3x3, PIPE_LATENCY=5, pix_valid held 1:
  - Exactly 18 res_valid pulses, raster order (0,0)..(5,2).
  - First pulse 5 cycles after the 3rd accepted beat.
  - frame_done 1 cycle after the 5-cycle FLUSH.
- Same frame, pix_valid deasserted 3 cycles after beat 4:
  - win_en=0 for those 3 cycles; results and coordinates unchanged; every pulse shifts by 3 cycles.
- Row boundary: beats col 0..1 of row 1 -> no res_valid for them; next pulse is (0,1).
- start pulsed during RUN and FLUSH -> ignored; exactly one frame_done.
- reset_n low for 1 cycle mid-row 1 -> all outputs 0, IDLE; a new start yields a full 18-result frame.
- With CONV_SCHED_PERF_CNT_EN and 7 idle RUN cycles -> stall_cycles=7 at frame_done; new start clears it to 0.
